// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, mode and FSM encodings, and the address helper
// used by the Kyber NTT/INTT scheduling logic.
package kyber_pkg;

  localparam int unsigned N       = 256;
  localparam int unsigned LOG_N   = 8;
  localparam int unsigned LAYERS  = 7;
  localparam int unsigned ZETA_W  = 7;
  localparam int unsigned F_SCALE = 1441;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'b00,
    MODE_INTT = 2'b01,
    MODE_IN   = 2'b10,
    MODE_OUT  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DRAIN,
    ST_IO,
    ST_FIN
  } state_e;

  // Butterfly operand A address: butterfly index c with a 0 inserted at bit k,
  // where k = log2(len). Equivalent to 2*len*(c/len) + c%len.
  function automatic logic [LOG_N-1:0] bf_addr_a(input logic [LOG_N-2:0] c,
                                                 input logic [2:0]       k);
    logic [LOG_N-1:0] cw;
    logic [LOG_N-1:0] mask;
    cw   = {1'b0, c};
    mask = (LOG_N'(1) << k) - LOG_N'(1);
    return (cw & mask) | ((cw & ~mask) << 1);
  endfunction

endpackage

// File: rtl/ntt_pipe_delay.sv
// ntt_pipe_delay: reset-clearable shift register of DEPTH stages.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   din      : WIDTH-bit input sampled every cycle
//   dout     : din delayed by DEPTH cycles
module ntt_pipe_delay #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_sched_ctrl.sv
// ntt_sched_ctrl: sequencer for the Kyber NTT/INTT butterfly datapath and the
// coefficient RAM load/unload stream.
//   start/mode_sel : pass request, mode latched when accepted in IDLE
//   busy/done      : pass in progress / one-cycle completion pulse
//   bf_*, addr_*, zeta_idx : butterfly read issue (0 when bf_valid is low)
//   wr_en, wr_addr_* : read issue delayed by PIPE_LAT for write-back
//   io_valid/io_ready/io_addr : sequential address stream for IN/OUT passes
module ntt_sched_ctrl
  import kyber_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  output logic              busy,
  output logic              done,
  output logic              bf_valid,
  output logic              bf_inv,
  output logic              bf_last,
  output logic [LOG_N-1:0]  addr_a,
  output logic [LOG_N-1:0]  addr_b,
  output logic [ZETA_W-1:0] zeta_idx,
  output logic              wr_en,
  output logic [LOG_N-1:0]  wr_addr_a,
  output logic [LOG_N-1:0]  wr_addr_b,
  output logic              io_valid,
  input  logic              io_ready,
  output logic [LOG_N-1:0]  io_addr
);

  localparam int unsigned CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned C_W   = LOG_N - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [C_W-1:0]   C_LAST   = '1;
  localparam logic [2:0]       L_LAST   = 3'(LAYERS - 1);
  localparam logic [LOG_N-1:0] IO_LAST  = LOG_N'(N - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [2:0]        l_q, l_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bf_valid_q, bf_valid_d;
  logic              bf_inv_q, bf_inv_d;
  logic              bf_last_q, bf_last_d;
  logic [LOG_N-1:0]  addr_a_q, addr_a_d;
  logic [LOG_N-1:0]  addr_b_q, addr_b_d;
  logic [ZETA_W-1:0] zeta_q, zeta_d;
  logic              io_valid_q, io_valid_d;
  logic [LOG_N-1:0]  io_addr_q, io_addr_d;

  logic              run_d;
  logic              intt_d;
  logic [2:0]        shamt;
  logic [LOG_N-1:0]  a_full;
  logic [C_W-1:0]    grp;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    l_d       = l_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    io_addr_d = io_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode_e'(mode_sel);
          l_d       = '0;
          c_d       = '0;
          cnt_d     = '0;
          io_addr_d = '0;
          state_d   = mode_sel[1] ? ST_IO : ST_RUN;
        end
      end
      ST_RUN: begin
        if (c_q == C_LAST) begin
          c_d   = '0;
          cnt_d = '0;
          if (l_q == L_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            l_d     = l_q + 3'd1;
            state_d = ST_GAP;
          end
        end else begin
          c_d = c_q + C_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) state_d = ST_FIN;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_IO: begin
        if (io_valid_q && io_ready) begin
          if (io_addr_q == IO_LAST) begin
            io_addr_d = '0;
            state_d   = ST_FIN;
          end else begin
            io_addr_d = io_addr_q + LOG_N'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the
    // state they describe.
    run_d  = (state_d == ST_RUN);
    intt_d = (mode_d == MODE_INTT);
    // log2(len): NTT len = 128>>l, INTT len = 2<<l.
    shamt  = intt_d ? (l_d + 3'd1) : (3'(LOG_N - 1) - l_d);
    a_full = bf_addr_a(c_d, shamt);
    grp    = c_d >> shamt;

    busy_d     = (state_d inside {ST_RUN, ST_GAP, ST_DRAIN, ST_IO});
    done_d     = (state_d == ST_FIN);
    bf_valid_d = run_d;
    bf_inv_d   = run_d && intt_d;
    bf_last_d  = run_d && intt_d && (l_d == L_LAST);
    addr_a_d   = run_d ? a_full : '0;
    addr_b_d   = run_d ? (a_full | (LOG_N'(1) << shamt)) : '0;
    // INTT index (128>>l) - 1 - g is written as (127>>l) - g to stay 7 bits wide.
    if (!run_d)      zeta_d = '0;
    else if (intt_d) zeta_d = (ZETA_W'(7'h7f) >> l_d) - grp;
    else             zeta_d = (ZETA_W'(1) << l_d) + grp;
    io_valid_d = (state_d == ST_IO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_NTT;
      l_q        <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      bf_inv_q   <= 1'b0;
      bf_last_q  <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      zeta_q     <= '0;
      io_valid_q <= 1'b0;
      io_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      l_q        <= l_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bf_valid_q <= bf_valid_d;
      bf_inv_q   <= bf_inv_d;
      bf_last_q  <= bf_last_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      zeta_q     <= zeta_d;
      io_valid_q <= io_valid_d;
      io_addr_q  <= io_addr_d;
    end
  end

  logic [2*LOG_N:0] dly_out;

  ntt_pipe_delay #(
    .WIDTH (2*LOG_N + 1),
    .DEPTH (PIPE_LAT)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bf_valid_q, addr_a_q, addr_b_q}),
    .dout (dly_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = dly_out;

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = bf_valid_q;
  assign bf_inv   = bf_inv_q;
  assign bf_last  = bf_last_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign zeta_idx = zeta_q;
  assign io_valid = io_valid_q;
  assign io_addr  = io_addr_q;

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// tb_ntt_sched_ctrl: directed bench for ntt_sched_ctrl. Expected butterfly
// sequences come from the reference Kyber ntt/invntt loop structure.
module tb_ntt_sched_ctrl;

  logic       clk, rst, start, io_ready;
  logic [1:0] mode_sel;
  logic       busy, done, bf_valid, bf_inv, bf_last, wr_en, io_valid;
  logic [7:0] addr_a, addr_b, wr_addr_a, wr_addr_b, io_addr;
  logic [6:0] zeta_idx;

  ntt_sched_ctrl #(.PIPE_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_sel  (mode_sel),
    .busy      (busy),
    .done      (done),
    .bf_valid  (bf_valid),
    .bf_inv    (bf_inv),
    .bf_last   (bf_last),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .zeta_idx  (zeta_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .io_valid  (io_valid),
    .io_ready  (io_ready),
    .io_addr   (io_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [53:0] obs_t;
  obs_t obs;
  assign obs = {busy, done, bf_valid, bf_inv, bf_last, addr_a, addr_b, zeta_idx,
                wr_en, wr_addr_a, wr_addr_b, io_valid, io_addr};

  int checks = 0;
  int failures = 0;

  logic [7:0] ma [2][896];
  logic [7:0] mb [2][896];
  logic [6:0] mz [2][896];

  typedef struct {
    logic [1:0] mode;
    int         cyc;
    logic       v;
    logic       last;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] z;
  } spot_t;

  typedef struct {
    logic       rdy;
    logic [7:0] addr;
  } io_vec_t;

  spot_t   spots [11];
  io_vec_t io_tab [5];

  task automatic chk(input string name, input int cyc, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic bsy, input logic dn, input logic v,
                              input logic inv, input logic last,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [6:0] z, input logic we,
                              input logic [7:0] wa, input logic [7:0] wb,
                              input logic iov, input logic [7:0] ioa);
    return {bsy, dn, v, inv, last, a, b, z, we, wa, wb, iov, ioa};
  endfunction

  // Software Kyber loop order: NTT zetas count up from 1, INTT down from 127.
  task automatic build_model();
    int i, k;
    i = 0; k = 1;
    for (int len = 128; len >= 2; len = len / 2)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ma[0][i] = 8'(j); mb[0][i] = 8'(j + len); mz[0][i] = 7'(k); i++;
        end
        k++;
      end
    i = 0; k = 127;
    for (int len = 2; len <= 128; len = len * 2)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ma[1][i] = 8'(j); mb[1][i] = 8'(j + len); mz[1][i] = 7'(k); i++;
        end
        k--;
      end
  endtask

  // Layer l issues in cycles 1+132*l .. 128+132*l.
  function automatic int idx_of(input int cyc);
    for (int l = 0; l < 7; l++)
      if (cyc >= 1 + 132 * l && cyc <= 128 + 132 * l)
        return l * 128 + cyc - 1 - 132 * l;
    return -1;
  endfunction

  function automatic obs_t exp_run(input int m, input int cyc);
    int i, iw;
    logic [7:0] a, b, wa, wb;
    logic [6:0] z;
    i = idx_of(cyc);
    iw = idx_of(cyc - 4);
    a = '0; b = '0; z = '0; wa = '0; wb = '0;
    if (i >= 0) begin a = ma[m][i]; b = mb[m][i]; z = mz[m][i]; end
    if (iw >= 0) begin wa = ma[m][iw]; wb = mb[m][iw]; end
    return mk(cyc >= 1 && cyc <= 924, cyc == 925, i >= 0, i >= 0 && m == 1,
              i >= 768 && m == 1, a, b, z, iw >= 0, wa, wb, 1'b0, 8'd0);
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; io_ready = 1'b0; mode_sel = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic start_pass(input logic [1:0] m);
    mode_sel = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input int m, input string name);
    int nvalid, ndone;
    nvalid = 0; ndone = 0;
    do_reset();
    start_pass(2'(m));
    for (int cyc = 1; cyc <= 930; cyc++) begin
      chk(name, cyc, 64'(obs), 64'(exp_run(m, cyc)));
      if (bf_valid) nvalid++;
      if (done) ndone++;
      @(negedge clk);
    end
    chk({name, "_nvalid"}, 930, 64'(nvalid), 64'd896);
    chk({name, "_ndone"}, 930, 64'(ndone), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=0 act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    spots[0]  = '{2'b00,   1, 1'b1, 1'b0,   8'd0, 8'd128, 7'd1};
    spots[1]  = '{2'b00, 129, 1'b0, 1'b0,   8'd0,   8'd0, 7'd0};
    spots[2]  = '{2'b00, 133, 1'b1, 1'b0,   8'd0,  8'd64, 7'd2};
    spots[3]  = '{2'b00, 197, 1'b1, 1'b0, 8'd128, 8'd192, 7'd3};
    spots[4]  = '{2'b00, 920, 1'b1, 1'b0, 8'd253, 8'd255, 7'd127};
    spots[5]  = '{2'b01,   1, 1'b1, 1'b0,   8'd0,   8'd2, 7'd127};
    spots[6]  = '{2'b01,   2, 1'b1, 1'b0,   8'd1,   8'd3, 7'd127};
    spots[7]  = '{2'b01,   3, 1'b1, 1'b0,   8'd4,   8'd6, 7'd126};
    spots[8]  = '{2'b01, 792, 1'b0, 1'b0,   8'd0,   8'd0, 7'd0};
    spots[9]  = '{2'b01, 793, 1'b1, 1'b1,   8'd0, 8'd128, 7'd1};
    spots[10] = '{2'b01, 920, 1'b1, 1'b1, 8'd127, 8'd255, 7'd1};
    io_tab[0] = '{1'b1, 8'd0};
    io_tab[1] = '{1'b0, 8'd1};
    io_tab[2] = '{1'b0, 8'd1};
    io_tab[3] = '{1'b1, 8'd1};
    io_tab[4] = '{1'b1, 8'd2};

    build_model();

    // Reset state
    rst = 1'b1; start = 1'b0; io_ready = 1'b0; mode_sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset", 0, 64'(obs), 64'd0);

    // Spot vectors
    for (int s = 0; s < 11; s++) begin
      do_reset();
      start_pass(spots[s].mode);
      repeat (spots[s].cyc - 1) @(negedge clk);
      chk("spot", spots[s].cyc, 64'({bf_valid, bf_last, addr_a, addr_b, zeta_idx}),
          64'({spots[s].v, spots[s].last, spots[s].a, spots[s].b, spots[s].z}));
    end

    // Full passes against the loop model, including write-back delay
    run_full(0, "ntt");
    run_full(1, "intt");

    // OUT mode start
    do_reset();
    start_pass(2'b11);
    chk("io_out_start", 1, 64'(obs), 64'(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,
        7'd0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0)));

    // IN mode: handshake table, then the rest of the pass with a mid-pass start
    begin
      logic [7:0] exp_addr;
      logic in_io, fin, rdy;
      int idle_cnt, ndone;
      do_reset();
      start_pass(2'b10);
      for (int i = 0; i < 5; i++) begin
        chk("io_hs", i + 1, 64'({io_valid, io_addr}), 64'({1'b1, io_tab[i].addr}));
        io_ready = io_tab[i].rdy;
        @(negedge clk);
      end
      exp_addr = 8'd3; in_io = 1'b1; fin = 1'b0; idle_cnt = 0; ndone = 0;
      for (int cyc = 6; cyc <= 700; cyc++) begin
        chk("io_pass", cyc, 64'(obs), 64'(mk(in_io, fin, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,
            7'd0, 1'b0, 8'd0, 8'd0, in_io, in_io ? exp_addr : 8'd0)));
        if (done) ndone++;
        if (!in_io && !fin) idle_cnt++;
        if (idle_cnt == 3) break;
        start = (cyc == 50);
        mode_sel = (cyc == 50) ? 2'b00 : 2'b10;
        rdy = (cyc % 4 != 2);
        io_ready = rdy;
        if (fin) fin = 1'b0;
        else if (in_io && rdy) begin
          if (exp_addr == 8'd255) begin in_io = 1'b0; fin = 1'b1; end
          else exp_addr = exp_addr + 8'd1;
        end
        @(negedge clk);
      end
      chk("io_ndone", 0, 64'(ndone), 64'd1);
      io_ready = 1'b0; start = 1'b0;
    end

    // Abort mid-NTT with asynchronous reset
    begin
      int nz;
      do_reset();
      start_pass(2'b00);
      repeat (399) @(negedge clk);
      chk("abort_pre", 400, 64'(obs), 64'(exp_run(0, 400)));
      rst = 1'b1;
      #1;
      chk("abort_async", 400, 64'(obs), 64'd0);
      nz = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (obs != '0) nz++;
      end
      chk("abort_quiet", 0, 64'(nz), 64'd0);
      start_pass(2'b00);
      chk("abort_restart", 1, 64'(obs), 64'(exp_run(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
